store_buff_ctrl: RTL and testbench

- Sequences one vector store through the lane store-buffer array.
- Accepts a store command from the memory control unit (M_CU) and configures the buffer array for the command's SEW.
- Collects element beats from the vector lanes into the buffer.
- Launches one AXI write transfer and drains the buffer onto the AXI write stream. It then reports completion.
- Sits between the M_CU, the store buffer array and the AXI master controller (AXIM_CTRL).

---
 rtl/store_buff_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_store_buff_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buff_ctrl.sv
// Store buffer controller: takes one store command from the M_CU, configures
// the lane store buffer for its SEW, collects lane beats, launches a single
// AXI write through AXIM_CTRL, drains the buffer, and signals completion.
module store_buff_ctrl #(
  parameter int VLEN               = 8192,
  parameter int V_LANE_NUM         = 8,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          st_start,
  output logic                          st_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] st_base_addr,
  input  logic [$clog2(VLEN):0]         st_vl,
  input  logic [1:0]                    st_sew,
  input  logic                          st_abort,
  output logic                          st_done,
  output logic [1:0]                    cfg_sew,
  output logic                          cfg_update,
  output logic                          cfg_rst,
  input  logic                          vlane_store_valid,
  output logic                          vlane_store_ready,
  output logic                          sbuff_whs,
  output logic                          sbuff_read_en,
  output logic                          sbuff_read_stall,
  output logic                          sbuff_rhs,
  output logic                          sbuff_read_flush,
  input  logic                          axi_wr_tvalid,
  input  logic                          axi_wr_tready,
  output logic                          ctrl_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  input  logic                          ctrl_done
);

  localparam int VL_W    = $clog2(VLEN) + 1;
  localparam int LANE_SH = $clog2(V_LANE_NUM);
  // Sized for the worst case: vl=VLEN at 32-bit elements.
  localparam int WB_W    = $clog2(VLEN / V_LANE_NUM) + 1;
  localparam int RB_W    = $clog2(VLEN) + 1;

  localparam logic [VL_W:0]              LANE_RND = (VL_W+1)'(V_LANE_NUM - 1);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] WORD_RND = C_XFER_SIZE_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WRITE,
    S_XFER,
    S_READ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                        state;
  logic [WB_W-1:0]               wbeats;
  logic [WB_W-1:0]               wcnt;
  logic [RB_W-1:0]               rbeats;
  logic [RB_W-1:0]               rcnt;
  logic                          done_seen;

  logic [1:0]                    sew_eff;
  logic [VL_W:0]                 vl_round;
  logic [C_XFER_SIZE_WIDTH-1:0]  bytes_in;
  logic                          active;
  logic                          abort_hit;

  assign sew_eff   = (st_sew == 2'd3) ? 2'd2 : st_sew;
  assign vl_round  = {1'b0, st_vl} + LANE_RND;
  assign bytes_in  = {{(C_XFER_SIZE_WIDTH-VL_W){1'b0}}, st_vl} << sew_eff;

  assign active    = (state != S_IDLE) && (state != S_DONE);
  // Reset outranks abort, so a simultaneous abort never flushes.
  assign abort_hit = st_abort & active & ~rst;

  assign sbuff_whs        = vlane_store_valid & vlane_store_ready;
  assign sbuff_rhs        = axi_wr_tvalid & axi_wr_tready & sbuff_read_en;
  assign sbuff_read_stall = sbuff_read_en & ~axi_wr_tready;
  assign sbuff_read_flush = abort_hit;
  assign cfg_rst          = cfg_update | abort_hit;

  // Main sequencer; per-state flags are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= S_IDLE;
      wbeats                  <= '0;
      wcnt                    <= '0;
      rbeats                  <= '0;
      rcnt                    <= '0;
      done_seen               <= 1'b0;
      cfg_sew                 <= '0;
      ctrl_addr_offset        <= '0;
      ctrl_xfer_size_in_bytes <= '0;
      st_ready                <= 1'b1;
      st_done                 <= 1'b0;
      cfg_update              <= 1'b0;
      vlane_store_ready       <= 1'b0;
      sbuff_read_en           <= 1'b0;
      ctrl_start              <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      ctrl_start <= 1'b0;
      st_done    <= 1'b0;
      if (abort_hit) begin
        state             <= S_DONE;
        wcnt              <= '0;
        rcnt              <= '0;
        done_seen         <= 1'b0;
        vlane_store_ready <= 1'b0;
        sbuff_read_en     <= 1'b0;
        st_done           <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (st_start) begin
              cfg_sew                 <= sew_eff;
              ctrl_addr_offset        <= st_base_addr;
              ctrl_xfer_size_in_bytes <= bytes_in;
              wbeats                  <= WB_W'(vl_round >> LANE_SH);
              rbeats                  <= RB_W'((bytes_in + WORD_RND) >> 2);
              wcnt                    <= '0;
              rcnt                    <= '0;
              done_seen               <= 1'b0;
              st_ready                <= 1'b0;
              if (st_vl == '0) begin
                state   <= S_DONE;
                st_done <= 1'b1;
              end else begin
                state      <= S_CFG;
                cfg_update <= 1'b1;
              end
            end
          end
          S_CFG: begin
            state             <= S_WRITE;
            wcnt              <= '0;
            vlane_store_ready <= 1'b1;
          end
          S_WRITE: begin
            if (sbuff_whs) begin
              wcnt <= wcnt + 1'b1;
              if (wcnt == wbeats - 1'b1) begin
                state             <= S_XFER;
                vlane_store_ready <= 1'b0;
                ctrl_start        <= 1'b1;
              end
            end
          end
          S_XFER: begin
            state         <= S_READ;
            rcnt          <= '0;
            sbuff_read_en <= 1'b1;
          end
          S_READ: begin
            if (ctrl_done) begin
              done_seen <= 1'b1;
            end
            if (sbuff_rhs) begin
              rcnt <= rcnt + 1'b1;
              if (rcnt == rbeats - 1'b1) begin
                state         <= S_WAIT;
                sbuff_read_en <= 1'b0;
              end
            end
          end
          S_WAIT: begin
            if (ctrl_done || done_seen) begin
              state     <= S_DONE;
              done_seen <= 1'b0;
              st_done   <= 1'b1;
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            st_ready <= 1'b1;
          end
          default: begin
            state    <= S_IDLE;
            st_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_store_buff_ctrl.sv
// Scoreboard bench for store_buff_ctrl: stimulus pushes the expected outcome
// of each store command, a monitor pops and compares on DUT output events.
module tb_store_buff_ctrl;

  localparam int VLEN  = 8192;
  localparam int LANES = 8;
  localparam int VL_W  = $clog2(VLEN) + 1;

  typedef struct {
    logic [31:0] base;
    int          vl;
    int          sew_e;
    int          wbeats;
    int          size;
    int          rbeats;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            st_start = 1'b0;
  logic            st_ready;
  logic [31:0]     st_base_addr = '0;
  logic [VL_W-1:0] st_vl = '0;
  logic [1:0]      st_sew = '0;
  logic            st_abort = 1'b0;
  logic            st_done;
  logic [1:0]      cfg_sew;
  logic            cfg_update;
  logic            cfg_rst;
  logic            vlane_store_valid = 1'b0;
  logic            vlane_store_ready;
  logic            sbuff_whs;
  logic            sbuff_read_en;
  logic            sbuff_read_stall;
  logic            sbuff_rhs;
  logic            sbuff_read_flush;
  logic            axi_wr_tvalid = 1'b0;
  logic            axi_wr_tready = 1'b0;
  logic            ctrl_start;
  logic [31:0]     ctrl_addr_offset;
  logic [31:0]     ctrl_xfer_size_in_bytes;
  logic            ctrl_done = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bit force_full    = 1'b0;
  bit force_stall   = 1'b0;
  bit done_mode     = 1'b0;
  bit exp_flush     = 1'b0;
  bit abort_pending = 1'b0;
  int done_timer    = 0;
  int direct_rbeats = 0;

  int whs_cnt = 0, rhs_cnt = 0, cfg_cnt = 0, start_cnt = 0;

  always #5 clk = ~clk;

  store_buff_ctrl #(
    .VLEN(VLEN),
    .V_LANE_NUM(LANES),
    .C_M_AXI_ADDR_WIDTH(32),
    .C_XFER_SIZE_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .st_start(st_start),
    .st_ready(st_ready),
    .st_base_addr(st_base_addr),
    .st_vl(st_vl),
    .st_sew(st_sew),
    .st_abort(st_abort),
    .st_done(st_done),
    .cfg_sew(cfg_sew),
    .cfg_update(cfg_update),
    .cfg_rst(cfg_rst),
    .vlane_store_valid(vlane_store_valid),
    .vlane_store_ready(vlane_store_ready),
    .sbuff_whs(sbuff_whs),
    .sbuff_read_en(sbuff_read_en),
    .sbuff_read_stall(sbuff_read_stall),
    .sbuff_rhs(sbuff_rhs),
    .sbuff_read_flush(sbuff_read_flush),
    .axi_wr_tvalid(axi_wr_tvalid),
    .axi_wr_tready(axi_wr_tready),
    .ctrl_start(ctrl_start),
    .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_done(ctrl_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return st_done;
      1:       return sbuff_read_en;
      2:       return vlane_store_ready;
      3:       return ctrl_done;
      default: return st_ready;
    endcase
  endfunction

  // Bounded wait on negedges until the selected signal is high.
  task automatic wait_out(input int which, input string name, input int budget);
    int   n;
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = pick(which);
    end while (s !== 1'b1 && n < budget);
    check(name, 64'(s), 64'(1));
  endtask

  // Issue one command when idle; push the outcome derived from the store rules.
  task automatic issue(input logic [31:0] base, input int vl, input int sew);
    exp_t e;
    int   n;
    n = 0;
    @(posedge clk); #1;
    while (st_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_start", 64'(st_ready), 64'(1));
    e.base   = base;
    e.vl     = vl;
    e.sew_e  = (sew == 3) ? 2 : sew;
    e.wbeats = (vl + LANES - 1) / LANES;
    e.size   = vl * (1 << e.sew_e);
    e.rbeats = (e.size + 3) / 4;
    exp_q.push_back(e);
    st_start     = 1'b1;
    st_base_addr = base;
    st_vl        = VL_W'(vl);
    st_sew       = 2'(sew);
    @(posedge clk); #1;
    st_start = 1'b0;
  endtask

  // Environment: lane/AXI handshake traffic and AXIM_CTRL completion.
  initial begin
    forever begin
      @(posedge clk); #1;
      vlane_store_valid = force_full ? 1'b1 : ($urandom_range(0, 3) != 0);
      axi_wr_tvalid     = force_full ? 1'b1 : ($urandom_range(0, 3) != 0);
      axi_wr_tready     = force_stall ? 1'b0 : (force_full ? 1'b1 : ($urandom_range(0, 3) != 0));
      ctrl_done = 1'b0;
      if (rst || st_done) begin
        done_timer = 0;
      end else if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) ctrl_done = 1'b1;
      end
      if (ctrl_start && !rst) begin
        done_timer = done_mode ? direct_rbeats : int'($urandom_range(1, 80));
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        whs_cnt = 0; rhs_cnt = 0; cfg_cnt = 0; start_cnt = 0;
      end else begin
        check("flush", 64'(sbuff_read_flush), 64'(exp_flush));
        check("cfg_rst", 64'(cfg_rst), 64'(cfg_update | exp_flush));
        check("read_stall", 64'(sbuff_read_stall), 64'(sbuff_read_en & ~axi_wr_tready));
        check("whs", 64'(sbuff_whs), 64'(vlane_store_valid & vlane_store_ready));
        check("rhs", 64'(sbuff_rhs), 64'(axi_wr_tvalid & axi_wr_tready & sbuff_read_en));
        if (sbuff_whs) whs_cnt++;
        if (sbuff_rhs) rhs_cnt++;
        if (cfg_update) begin
          cfg_cnt++;
          if (exp_q.size() == 0) begin
            check("cfg_unexpected", 64'(cfg_update), 64'(0));
          end else begin
            check("cfg_sew", 64'(cfg_sew), 64'(exp_q[0].sew_e));
            check("cfg_on_nonzero_vl", 64'(exp_q[0].vl != 0), 64'(1));
          end
        end
        if (ctrl_start) begin
          start_cnt++;
          if (exp_q.size() == 0) begin
            check("start_unexpected", 64'(ctrl_start), 64'(0));
          end else begin
            check("ctrl_addr", 64'(ctrl_addr_offset), 64'(exp_q[0].base));
            check("ctrl_size", 64'(ctrl_xfer_size_in_bytes), 64'(exp_q[0].size));
            check("whs_before_start", 64'(whs_cnt), 64'(exp_q[0].wbeats));
            check("cfg_before_start", 64'(cfg_cnt), 64'(1));
          end
        end
        if (st_done) begin
          if (exp_q.size() == 0) begin
            check("done_unexpected", 64'(st_done), 64'(0));
          end else begin
            e = exp_q.pop_front();
            if (abort_pending) begin
              check("abort_partial_drain", 64'(rhs_cnt < e.rbeats), 64'(1));
              abort_pending = 1'b0;
            end else begin
              check("done_whs_cnt", 64'(whs_cnt), 64'(e.wbeats));
              check("done_rhs_cnt", 64'(rhs_cnt), 64'(e.rbeats));
              check("done_cfg_cnt", 64'(cfg_cnt), 64'(e.vl != 0));
              check("done_start_cnt", 64'(start_cnt), 64'(e.vl != 0));
              if (e.vl != 0) begin
                check("done_addr_hold", 64'(ctrl_addr_offset), 64'(e.base));
                check("done_size_hold", 64'(ctrl_xfer_size_in_bytes), 64'(e.size));
              end
            end
          end
          whs_cnt = 0; rhs_cnt = 0; cfg_cnt = 0; start_cnt = 0;
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  // Stimulus.
  initial begin
    int vl_r;
    int sew_r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_st_ready", 64'(st_ready), 64'(1));
    check("rst_st_done", 64'(st_done), 64'(0));
    check("rst_cfg_update", 64'(cfg_update), 64'(0));
    check("rst_cfg_sew", 64'(cfg_sew), 64'(0));
    check("rst_vlane_ready", 64'(vlane_store_ready), 64'(0));
    check("rst_read_en", 64'(sbuff_read_en), 64'(0));
    check("rst_ctrl_start", 64'(ctrl_start), 64'(0));
    check("rst_ctrl_addr", 64'(ctrl_addr_offset), 64'(0));
    check("rst_ctrl_size", 64'(ctrl_xfer_size_in_bytes), 64'(0));

    // SEW=32, vl=16 at 0x1000.
    issue(32'h0000_1000, 16, 2);
    wait_out(0, "done_timeout_basic", 2000);

    // SEW=8, vl=13 with a 3-cycle tready stall mid-drain.
    force_full = 1'b1;
    issue(32'h0000_2000, 13, 0);
    wait_out(1, "read_en_wait_stall", 200);
    repeat (3) begin
      @(posedge clk);
      force_stall = 1'b1;
      @(negedge clk);
      check("stall_asserted", 64'(sbuff_read_stall), 64'(1));
      check("stall_no_rhs", 64'(sbuff_rhs), 64'(0));
      check("stall_in_read", 64'(sbuff_read_en), 64'(1));
    end
    @(posedge clk);
    force_stall = 1'b0;
    wait_out(0, "done_timeout_stall", 500);
    force_full = 1'b0;

    // vl=0 goes straight to DONE.
    issue(32'h0000_0400, 0, 1);
    @(negedge clk);
    check("vl0_done", 64'(st_done), 64'(1));
    @(negedge clk);
    check("vl0_done_single", 64'(st_done), 64'(0));
    check("vl0_ready", 64'(st_ready), 64'(1));

    // Abort on the 5th READ cycle.
    issue(32'h0000_6000, 64, 2);
    wait_out(1, "read_en_wait_abort", 500);
    repeat (4) @(posedge clk);
    #1;
    abort_pending = 1'b1;
    exp_flush     = 1'b1;
    st_abort      = 1'b1;
    @(negedge clk);
    check("abort_in_read", 64'(sbuff_read_en), 64'(1));
    check("abort_cfg_rst", 64'(cfg_rst), 64'(1));
    @(posedge clk); #1;
    st_abort  = 1'b0;
    exp_flush = 1'b0;
    @(negedge clk);
    check("abort_done", 64'(st_done), 64'(1));
    @(negedge clk);
    check("abort_ready_after", 64'(st_ready), 64'(1));
    check("abort_done_single", 64'(st_done), 64'(0));

    // Abort while idle is ignored.
    @(posedge clk); #1;
    st_abort = 1'b1;
    @(negedge clk);
    check("idle_abort_ready", 64'(st_ready), 64'(1));
    @(posedge clk); #1;
    st_abort = 1'b0;
    @(negedge clk);
    check("idle_abort_no_done", 64'(st_done), 64'(0));
    check("idle_abort_still_ready", 64'(st_ready), 64'(1));

    // Second start during WRITE is ignored.
    issue(32'h0000_3000, 40, 1);
    wait_out(2, "vready_wait", 200);
    @(posedge clk); #1;
    st_start     = 1'b1;
    st_base_addr = 32'hDEAD_0000;
    st_vl        = VL_W'(100);
    st_sew       = 2'd0;
    @(negedge clk);
    check("busy_not_ready", 64'(st_ready), 64'(0));
    @(posedge clk); #1;
    st_start = 1'b0;
    wait_out(0, "done_timeout_second", 2000);

    // Reset in READ, with a concurrent abort: no done, no flush.
    issue(32'h0000_4000, 32, 2);
    wait_out(1, "read_en_wait_rst", 500);
    @(posedge clk); #1;
    rst      = 1'b1;
    st_abort = 1'b1;
    @(negedge clk);
    check("rst_mid_no_flush", 64'(sbuff_read_flush), 64'(0));
    check("rst_mid_no_done", 64'(st_done), 64'(0));
    @(posedge clk); #1;
    rst      = 1'b0;
    st_abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_ready", 64'(st_ready), 64'(1));
    check("rst_mid_read_en", 64'(sbuff_read_en), 64'(0));
    check("rst_mid_done_after", 64'(st_done), 64'(0));
    @(negedge clk);
    check("rst_mid_done_later", 64'(st_done), 64'(0));

    // ctrl_done on the final rhs: one WAIT cycle then done.
    force_full    = 1'b1;
    done_mode     = 1'b1;
    direct_rbeats = 12;
    issue(32'h0000_5000, 24, 1);
    wait_out(3, "ctrl_done_wait", 200);
    check("last_rhs_with_done", 64'(sbuff_rhs), 64'(1));
    @(negedge clk);
    check("wait_read_en_low", 64'(sbuff_read_en), 64'(0));
    check("wait_not_done", 64'(st_done), 64'(0));
    @(negedge clk);
    check("done_after_wait", 64'(st_done), 64'(1));
    done_mode  = 1'b0;
    force_full = 1'b0;

    // Boundary lengths.
    issue(32'h0000_000C, 1, 0);
    wait_out(0, "done_timeout_vl1", 500);
    issue(32'h0000_0100, 8, 1);
    wait_out(0, "done_timeout_vl8", 500);
    issue(32'h0000_0200, 9, 3);
    wait_out(0, "done_timeout_vl9", 500);

    // Randomized commands.
    for (int t = 0; t < 20; t++) begin
      vl_r  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 200));
      sew_r = int'($urandom_range(0, 3));
      issue($urandom, vl_r, sew_r);
      wait_out(0, "done_timeout_rand", 5000);
    end

    // Maximum vl with SEW code 3 (treated as 32-bit).
    issue(32'h8000_0000, VLEN, 3);
    wait_out(0, "done_timeout_max", 40000);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
